// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: tracks destination tags of the EX/MEM/WB stages for a
// 5-stage pipeline, chooses operand forwarding sources, generates load-use
// (or plain RAW) stalls, drives the WB register-file write port and
// sequences a halt so that every older write retires before hlt_out rises.
//
// Build option: define HAZARD_FWD_EN to enable EX/MEM forwarding. When it is
// left undefined, fwd*_sel stay at 00 and decode stalls until the producer
// has reached WB.
//
// Halt FSM
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_RUN    | normal issue from decode
//   ST_DRAIN  | halt accepted; decode frozen, in-flight slots retiring
//   ST_HALTED | halt tag has left WB; hlt_out high until reset
module hazard_fwd_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [3:0]  id_p0_addr,
  input  logic [3:0]  id_p1_addr,
  input  logic        id_re0,
  input  logic        id_re1,
  input  logic [3:0]  id_dst_addr,
  input  logic        id_we,
  input  logic        id_is_load,
  input  logic        id_hlt,
  input  logic [15:0] mem_result,
  output logic        stall,
  output logic [1:0]  fwd0_sel,
  output logic [1:0]  fwd1_sel,
  output logic [3:0]  rf_dst_addr,
  output logic [15:0] rf_dst,
  output logic        rf_we,
  output logic        hlt_out
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  typedef struct packed {
    logic       valid;
    logic       we;
    logic [3:0] dst_addr;
    logic       is_load;
    logic       hlt;
  } tag_t;

  tag_t        ex_q, ex_d;
  tag_t        mem_q, mem_d;
  tag_t        wb_q, wb_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic [1:0]  fsm_q, fsm_d;

  logic        p0_ex, p1_ex, p0_mem, p1_mem;
  logic        hazard;
  logic        stall_int;
  logic        accept;
  logic [1:0]  sel0, sel1;

  // R0 is hardwired, so a write to it never produces a dependency.
  function automatic logic slot_match(input logic re, input logic [3:0] addr,
                                      input tag_t s);
    return re & s.valid & s.we & (s.dst_addr == addr) & (addr != 4'd0);
  endfunction

  // Operand dependency detection, stall and forwarding selection.
  always_comb begin
    p0_ex  = slot_match(id_re0, id_p0_addr, ex_q);
    p1_ex  = slot_match(id_re1, id_p1_addr, ex_q);
    p0_mem = slot_match(id_re0, id_p0_addr, mem_q);
    p1_mem = slot_match(id_re1, id_p1_addr, mem_q);
    hazard = 1'b0;
    sel0   = SEL_RF;
    sel1   = SEL_RF;
`ifdef HAZARD_FWD_EN
    // Only a load in EX cannot be bypassed: its data arrives one stage later.
    hazard = (p0_ex | p1_ex) & ex_q.is_load;
    if (p0_ex && !ex_q.is_load) sel0 = SEL_EX;
    else if (p0_mem)            sel0 = SEL_MEM;
    if (p1_ex && !ex_q.is_load) sel1 = SEL_EX;
    else if (p1_mem)            sel1 = SEL_MEM;
`else
    hazard = p0_ex | p1_ex | p0_mem | p1_mem;
`endif
    stall_int = (fsm_q != ST_RUN) | (id_valid & hazard);
    accept    = id_valid & ~stall_int;
  end

  // Next-state for the tag pipeline and the halt sequencer.
  always_comb begin
    ex_d      = '0;
    if (accept) begin
      ex_d.valid    = 1'b1;
      ex_d.we       = id_we;
      ex_d.dst_addr = id_dst_addr;
      ex_d.is_load  = id_is_load;
      ex_d.hlt      = id_hlt;
    end
    mem_d     = ex_q;
    wb_d      = mem_q;
    wb_data_d = mem_result;
    fsm_d     = fsm_q;
    case (fsm_q)
      ST_RUN:    if (accept && id_hlt)         fsm_d = ST_DRAIN;
      ST_DRAIN:  if (wb_q.valid && wb_q.hlt)   fsm_d = ST_HALTED;
      ST_HALTED: fsm_d = ST_HALTED;
      default:   fsm_d = ST_RUN;
    endcase
  end

  // Pipeline tag registers and FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      wb_data_q <= '0;
      fsm_q     <= ST_RUN;
    end else begin
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
      wb_data_q <= wb_data_d;
      fsm_q     <= fsm_d;
    end
  end

  // Outputs are forced quiet while rst is high so an in-flight write or a
  // held halt cannot leak through during the reset cycle itself.
  always_comb begin
    stall       = ~rst & stall_int;
    fwd0_sel    = rst ? SEL_RF : sel0;
    fwd1_sel    = rst ? SEL_RF : sel1;
    rf_we       = ~rst & wb_q.valid & wb_q.we & (wb_q.dst_addr != 4'd0);
    rf_dst_addr = wb_q.dst_addr;
    rf_dst      = wb_data_q;
    hlt_out     = ~rst & (fsm_q == ST_HALTED);
  end

endmodule

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: id_valid  in  1  decode slot holds a real instruction.
REQ-004 SHALL have ports: id_p0_addr, id_p1_addr  in  4 each  source register addresses of decode slot.
REQ-005 SHALL have ports: id_re0, id_re1  in  1 each  source operand used.
REQ-006 SHALL have ports: id_dst_addr  in  4  destination register; id_we  in  1  instruction writes a register; id_is_load  in  1  result comes from memory.
REQ-007 SHALL have ports: id_hlt  in  1  decode slot is a halt instruction.
REQ-008 SHALL have ports: mem_result  in  16  result of the instruction currently in MEM (ALU value or load data).
REQ-009 SHALL have ports: stall  out  1  hold PC/IF/ID, inject bubble into EX.
REQ-010 SHALL have ports: fwd0_sel, fwd1_sel  out  2 each  operand source: 00 register file, 01 EX result, 10 MEM result.
REQ-011 SHALL have ports: rf_dst_addr  out  4, rf_dst  out  16, rf_we  out  1  register-file write port, WB stage.
REQ-012 SHALL have ports: hlt_out  out  1  halt has retired; drives register-file dump.

Function
REQ-013 SHALL keep three tag slots EX, MEM, WB, each {valid, we, dst_addr, is_load, hlt}; WB additionally holds 16-bit data.
REQ-014 Each cycle SHALL advance EX<-decode (if id_valid & ~stall, else bubble with valid=0, we=0), MEM<-EX, WB<-MEM with WB data<-mem_result.
REQ-015 rf_we SHALL equal WB.valid & WB.we & (WB.dst_addr!=0); rf_dst_addr=WB.dst_addr; rf_dst=WB data; combinational from WB slot.
REQ-016 A write in WB SHALL need no forwarding: register file writes clock high and reads clock low of the same cycle.
REQ-017 Operand n "matches" a slot when id_ren & slot.valid & slot.we & slot.dst_addr==id_pn_addr & id_pn_addr!=0; R0 SHALL never match.
REQ-018 Forward priority SHALL be youngest first: EX match (non-load) -> 01; else MEM match -> 10; else 00.
REQ-019 Load-use: EX match with EX.is_load SHALL assert stall for exactly one cycle; next cycle the load is in MEM and selects 10.
REQ-020 stall and fwd*_sel SHALL be combinational from current slots and decode inputs; zero added latency.
REQ-021 stall SHALL be ignored when id_valid=0 (no stall from bubbles/garbage addresses).
REQ-022 Halt FSM states RUN, DRAIN, HALTED: RUN->DRAIN when id_valid & id_hlt & ~stall; DRAIN->HALTED when halt tag reaches WB; HALTED held until reset.
REQ-023 In DRAIN and HALTED, stall SHALL be 1 and no new instruction enters EX; in-flight slots keep draining.
REQ-024 hlt_out SHALL be 1 only in HALTED, rising the cycle after the halt occupies WB (all older writes retired).

Reset
REQ-025 On rst: all slot valid/we/hlt=0, dst_addr=0, WB data=0, FSM=RUN.
REQ-026 Outputs in reset cycle and cycle after: stall=0, fwd*_sel=00, rf_we=0, hlt_out=0.
REQ-027 rst mid-operation (including DRAIN/HALTED) SHALL discard all in-flight writes; no rf_we after rst rises.

Configuration
REQ-028 Macro HAZARD_FWD_EN SHALL select forwarding.
REQ-029 Defined: behaviour per REQ-018/019.
REQ-030 Undefined: fwd*_sel tied 00; stall asserted while any operand matches EX or MEM slot (up to two bubbles), load flag irrelevant.

Verification
REQ-031 ADD R3 then SUB using R3 on p0 next cycle -> fwd0_sel=01, stall=0 (FWD_EN); without macro -> two stall cycles, sel 00.
REQ-032 LW R5 then ADD R5,R5 -> one stall cycle, then fwd0_sel=fwd1_sel=10; mem_result 16'hBEEF appears on rf_dst with rf_dst_addr=5 two cycles later.
REQ-033 Write to R0 followed by read of R0 -> no stall, sel 00, rf_we=0.
REQ-034 R2 written in EX and MEM simultaneously, read R2 -> sel 01 (youngest wins).
REQ-035 ADD R1; HLT -> stall=1 from cycle after HLT accepted, rf_we for R1 seen, hlt_out=1 after HLT leaves WB; rst then clears hlt_out and stall.
